// File: rtl/pipe_test_pkg.sv
// Shared definitions for the pipe benchmark data source: pattern codes,
// generator taps, the block FSM state type and the pattern step function.
package pipe_test_pkg;

  localparam logic [2:0]  PAT_COUNT = 3'd0;
  localparam logic [2:0]  PAT_LFSR  = 3'd1;
  localparam logic [2:0]  PAT_WALK  = 3'd2;
  localparam logic [2:0]  PAT_ALT   = 3'd3;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] ALT_START = 32'h5555_5555;

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    ARMED     = 2'd1,
    XFER      = 2'd2
  } pipe_state_e;

  // Next generator value; unused pattern codes behave as count-up.
  function automatic logic [31:0] gen_next(input logic [2:0] pat, input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = cur;
    case (pat)
      PAT_COUNT: nxt = cur + 32'd1;
      PAT_LFSR:  nxt = cur[0] ? ({1'b0, cur[31:1]} ^ LFSR_TAPS) : {1'b0, cur[31:1]};
      PAT_WALK:  nxt = {cur[30:0], cur[31]};
      PAT_ALT:   nxt = ~cur;
      default:   nxt = cur + 32'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bt_pipe_out_source_if.sv
// Host pipe-out endpoint bundle: read/blockstrobe from the host, data/ready back.
interface bt_pipe_out_source_if;
  logic        pipe_out_read;
  logic        pipe_out_blockstrobe;
  logic [31:0] pipe_out_data;
  logic        pipe_out_ready;

  modport master (
    output pipe_out_read,
    output pipe_out_blockstrobe,
    input  pipe_out_data,
    input  pipe_out_ready
  );

  modport slave (
    input  pipe_out_read,
    input  pipe_out_blockstrobe,
    output pipe_out_data,
    output pipe_out_ready
  );
endinterface

// File: rtl/pipe_fifo_sync.sv
// Single-clock FIFO with synchronous flush; the head word is visible
// combinationally so the consumer can register it on the pop edge.
module pipe_fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      fill_q;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full_o    = (fill_q == (AW+1)'(DEPTH));
  assign empty_o   = (fill_q == '0);
  assign fill_o    = fill_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr_s   = wr_en_i & ~full_o;
  assign do_rd_s   = rd_en_i & ~empty_o;

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr_s, do_rd_s})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/bt_pipe_out_source.sv
// Block-throttled pipe-out data source: throttled pattern generator feeding a
// FIFO, block-ready FSM toward the host endpoint, and delivery counters.
module bt_pipe_out_source
  import pipe_test_pkg::*;
#(
  parameter int          BLOCK_WORDS = 256,
  parameter int          FIFO_DEPTH  = 1024,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic                    okClk,
  input  logic                    reset,
  input  logic [2:0]              pattern,
  input  logic                    throttle_set,
  input  logic [31:0]             throttle_val,
  bt_pipe_out_source_if.slave     ep,
  output logic [31:0]             words_sent,
  output logic                    underflow_err
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  logic [2:0]    pat_q;
  logic [31:0]   gen_q;
  logic [31:0]   thr_q;
  logic [31:0]   data_q;
  logic [31:0]   sent_q;
  logic          uf_q;
  logic          ready_q;
  logic          avail_q;
  pipe_state_e   state_q;
  logic [CW-1:0] blk_cnt_q;

  logic          wr_en_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [FW-1:0] fifo_fill_s;
  logic [31:0]   fifo_head_s;
  logic          fill_ok_s;

  assign wr_en_s   = thr_q[0] & ~fifo_full_s;
  assign fill_ok_s = (fifo_fill_s >= FW'(BLOCK_WORDS));

  pipe_fifo_sync #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (okClk),
    .rst_i     (reset),
    .wr_en_i   (wr_en_s),
    .wr_data_i (gen_q),
    .rd_en_i   (ep.pipe_out_read),
    .rd_data_o (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .fill_o    (fifo_fill_s)
  );

  // Throttle mask and pattern generator; the generator only advances on an accepted write.
  always_ff @(posedge okClk) begin
    if (reset) begin
      pat_q <= pattern;
      gen_q <= (pattern == PAT_ALT) ? ALT_START : SEED;
      thr_q <= 32'hFFFF_FFFF;
    end else begin
      thr_q <= throttle_set ? throttle_val : {thr_q[30:0], thr_q[31]};
      if (wr_en_s) begin
        gen_q <= gen_next(pat_q, gen_q);
      end else begin
        gen_q <= gen_q;
      end
    end
  end

  // Read path: data and word count update the cycle after a pop; empty reads are sticky errors.
  always_ff @(posedge okClk) begin
    if (reset) begin
      data_q <= 32'd0;
      sent_q <= 32'd0;
      uf_q   <= 1'b0;
    end else if (ep.pipe_out_read) begin
      if (fifo_empty_s) begin
        uf_q <= 1'b1;
      end else begin
        data_q <= fifo_head_s;
        sent_q <= sent_q + 32'd1;
      end
    end else begin
      data_q <= data_q;
    end
  end

  // Block FSM. avail_q delays the fill test one cycle; the live fill is re-checked
  // so a stale flag cannot arm after the last read of a block drained it.
  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q   <= WAIT_FILL;
      ready_q   <= 1'b0;
      avail_q   <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      avail_q <= fill_ok_s;
      case (state_q)
        WAIT_FILL: begin
          if (avail_q && fill_ok_s) begin
            state_q <= ARMED;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        ARMED: begin
          if (ep.pipe_out_read) begin
            state_q   <= XFER;
            ready_q   <= 1'b0;
            blk_cnt_q <= CW'(1);
          end else if (ep.pipe_out_blockstrobe) begin
            state_q   <= XFER;
            ready_q   <= 1'b0;
            blk_cnt_q <= '0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        XFER: begin
          ready_q <= 1'b0;
          if (ep.pipe_out_read) begin
            if (blk_cnt_q == CW'(BLOCK_WORDS - 1)) begin
              state_q   <= WAIT_FILL;
              blk_cnt_q <= '0;
            end else begin
              blk_cnt_q <= blk_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q   <= WAIT_FILL;
          ready_q   <= 1'b0;
          blk_cnt_q <= '0;
        end
      endcase
    end
  end

  assign ep.pipe_out_data  = data_q;
  assign ep.pipe_out_ready = ready_q;
  assign words_sent        = sent_q;
  assign underflow_err     = uf_q;

endmodule
